// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- read-side stream of the UART receive FIFO.
//
// Handshake: a byte moves from master to slave on a rising clk edge where
// dout_valid and dout_ready are both 1. The master holds dout stable while
// dout_valid=1 and the byte has not been taken. dout_ready may be asserted
// at any time. When dout_valid=0 it has no effect, and dout is don't-care.
//
// Signals:
//   dout        8  head-of-FIFO byte (master -> slave)
//   dout_valid  1  dout holds a valid byte (master -> slave)
//   dout_ready  1  consumer accepts dout this cycle (slave -> master)
interface uart_rx_fifo_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- captures each byte from a UART receiver into a
// first-word-fall-through FIFO.
//
// A byte is pushed on the falling edge of the receiver busy flag rx_int.
// A byte that arrives while the FIFO is full and not being popped is
// dropped, and the sticky overflow flag is set.
//
// Ports:
//   clk       in   system clock; all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset (control state only)
//   rx_int    in   receiver busy; falls when a byte completes
//   rx_data   in   received byte, valid once rx_int is sampled low
//   out_if    mst  dout / dout_valid / dout_ready read stream
//   count     out  bytes stored, 0..DEPTH
//   full      out  count == DEPTH
//   empty     out  count == 0
//   overflow  out  sticky: a byte was dropped because the FIFO was full
//   clr_ovf   in   synchronous clear of overflow (a coincident set wins)
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_int,
  input  logic [7:0]      rx_data,
  uart_rx_fifo_if.master  out_if,
  output logic [AW:0]     count,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  input  logic            clr_ovf
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic          rx_int_d;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;

  logic push;
  logic pop;
  logic wr_en;
  logic ovf_set;

  // rx_int_d resets to 0. A low rx_int at reset release therefore looks
  // like "held low" and does not push.
  assign push    = rx_int_d & ~rx_int;
  assign pop     = out_if.dout_valid & out_if.dout_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;

  assign out_if.dout_valid = ~empty;
  assign out_if.dout       = mem[rd_ptr];

  // Storage is data only and is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_int_d   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_int_d <= rx_int;
      // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)      overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed and random stimulus for uart_rx_fifo. A
// queue-based model of the FIFO produces every expected value.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rx_int = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_ovf = 1'b0;
  logic [AW:0] count;
  logic        full, empty, overflow;

  uart_rx_fifo_if u_if ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_int   (rx_int),
    .rx_data  (rx_data),
    .out_if   (u_if.master),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // reference model: contents in order, sticky flag, last sampled rx_int
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_prev = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ":empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, ":full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":dout_valid"}, 32'(u_if.dout_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, ":dout"}, 32'(u_if.dout), 32'(exp_q[0]));
  endtask

  // One clock cycle. The task is entered 1 time unit after a rising edge.
  // It drives the inputs, advances the model by one edge, and checks after
  // that edge.
  task automatic cycle(input logic ri, input logic [7:0] d, input logic rdy,
                       input logic clr, input string tag);
    logic push_m, pop_m;
    rx_int         = ri;
    rx_data        = d;
    u_if.dout_ready = rdy;
    clr_ovf        = clr;
    push_m = m_prev & ~ri;
    pop_m  = rdy & (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (pop_m) void'(exp_q.pop_front());
    if (clr) m_ovf = 1'b0;
    if (push_m) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
    m_prev = ri;
    check_state(tag);
  endtask

  // A complete receiver frame: busy high for one cycle, then fall with data.
  task automatic frame(input logic [7:0] d, input logic rdy, input string tag);
    cycle(1'b1, 8'h00, rdy, 1'b0, tag);
    cycle(1'b0, d, rdy, 1'b0, tag);
  endtask

  initial begin
    u_if.dout_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset:empty_const", 32'(empty), 32'd1);
    rst_n = 1'b1;

    // a single frame; the byte is visible on the next cycle
    frame(8'hA5, 1'b0, "single");
    chk("single:dout_a5", 32'(u_if.dout), 32'h0000_00A5);
    chk("single:count1", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");

    // dout_ready on an empty FIFO has no effect
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "ready_empty");

    // fill with 01..10, then drain in order
    for (int i = 1; i <= 16; i++) frame(8'(i), 1'b0, "fill");
    chk("fill:full_const", 32'(full), 32'd1);
    chk("fill:count16", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    chk("drain:empty_const", 32'(empty), 32'd1);

    // overflow: push FF into a full FIFO; set beats a coincident clear
    for (int i = 0; i < 16; i++) frame(8'(8'h20 + i), 1'b0, "fill2");
    frame(8'hFF, 1'b0, "ovf");
    chk("ovf:set", 32'(overflow), 32'd1);
    chk("ovf:count16", 32'(count), 32'd16);
    cycle(1'b1, 8'h00, 1'b0, 1'b0, "ovf_setclr_a");
    cycle(1'b0, 8'hFE, 1'b0, 1'b1, "ovf_setclr_b");
    chk("ovf:set_wins", 32'(overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "ovf_clr");
    chk("ovf:cleared", 32'(overflow), 32'd0);

    // push and pop together while full
    cycle(1'b1, 8'h00, 1'b0, 1'b0, "fullpp_a");
    cycle(1'b0, 8'h55, 1'b1, 1'b0, "fullpp_b");
    chk("fullpp:count16", 32'(count), 32'd16);
    chk("fullpp:ovf0", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "fullpp_drain");

    // 20 bytes interleaved with pops; the pointers wrap
    for (int i = 0; i < 20; i++) frame(8'(8'h80 + i), 1'b1, "wrap");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap_tail");

    // reset with five bytes stored
    for (int i = 0; i < 5; i++) frame(8'(8'hC0 + i), 1'b0, "pre_rst");
    chk("pre_rst:count5", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    check_state("mid_rst");
    chk("mid_rst:dv0", 32'(u_if.dout_valid), 32'd0);
    rx_int = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h77, 1'b0, 1'b0, "post_rst_low");
    chk("post_rst:nopush", 32'(count), 32'd0);
    frame(8'h3C, 1'b0, "post_rst_frame");

    // random: first mostly-stalled consumer (fills, overflows), then mixed
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 15) == 0), "rand_stall");
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), "rand_mix");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_int  input  1  receiver busy flag; high during frame, falls at byte completion.
REQ-006 rx_data  input  8  received byte; valid from the cycle rx_int is first sampled low.
REQ-007 dout  output  8  head-of-FIFO byte (first-word-fall-through).
REQ-008 dout_valid  output  1  dout holds a valid byte.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 count  output  AW+1  bytes currently stored, 0..DEPTH.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 overflow  output  1  sticky: byte dropped because FIFO full.
REQ-014 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-015 Block SHALL register rx_int into rx_int_d every cycle; push = rx_int_d & ~rx_int (falling edge).
REQ-016 On an edge where push=1 and (not full or pop=1), rx_data SHALL be written at wr_ptr and wr_ptr incremented modulo DEPTH.
REQ-017 pop = dout_valid & dout_ready; on pop, rd_ptr SHALL increment modulo DEPTH.
REQ-018 dout SHALL equal mem[rd_ptr] combinationally; dout_valid SHALL equal ~empty.
REQ-019 Latency: byte written at edge N SHALL appear on dout with dout_valid=1 from edge N onward when FIFO was empty (visible in cycle after N).
REQ-020 count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-021 Push while full with pop in same cycle: both SHALL occur, count stays DEPTH, overflow unchanged.
REQ-022 Push while full without pop: byte SHALL be discarded, pointers/count unchanged, overflow set to 1.
REQ-023 Push and pop on empty FIFO same cycle: pop is impossible (dout_valid=0); push alone takes effect.
REQ-024 dout_ready while empty SHALL have no effect.
REQ-025 overflow: set on REQ-022 condition; cleared by clr_ovf; if set and clear coincide, set SHALL win.
REQ-026 Pointers SHALL be AW bits and wrap DEPTH-1 -> 0 without disturbing count.
REQ-027 Order SHALL be strict FIFO; no byte duplicated or reordered.
REQ-028 rx_int held high or held low SHALL generate no push; only a 1->0 transition pushes exactly one byte.
REQ-029 Storage array need not be reset; only control state is reset.

Reset
REQ-030 While rst_n=0: rx_int_d=0, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout_valid=0, overflow=0.
REQ-031 rst_n assertion mid-operation SHALL discard all stored bytes immediately; dout value is don't-care while dout_valid=0.
REQ-032 rx_int_d reset to 0 SHALL prevent a spurious push if rx_int is low at reset release.
REQ-033 First push after reset SHALL require rx_int to rise and fall after rst_n deasserts.

Verification
REQ-034 Reset, then one frame rx_int 1->0 with rx_data=8'hA5, dout_ready=0 -> next cycle dout_valid=1, dout=8'hA5, count=1.
REQ-035 Push 8'h01..8'h10 (16 bytes), dout_ready=0 -> full=1, count=16; then dout_ready=1 for 16 cycles -> dout reads 01..10 in order, empty=1.
REQ-036 Fill to 16, push 8'hFF with dout_ready=0 -> overflow=1, count=16, 8'hFF never output; pulse clr_ovf -> overflow=0.
REQ-037 Full FIFO, push 8'h55 in same cycle as pop -> count stays 16, 8'h55 emerges 16th after popped byte; overflow=0.
REQ-038 Push 20 bytes interleaved with pops (keep count<=3) -> pointers wrap, all 20 bytes output in order.
REQ-039 Assert rst_n=0 with count=5 -> count=0, empty=1, dout_valid=0 immediately; rx_int low at release -> no push.
